// File: rtl/ssegment_mux_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssegment_mux_display_pkg
//  Description : Shared constants for the multiplexed seven-segment display:
//                segment bit positions and the active-high hex glyph table.
//  Revision    : 1.0 - initial release
// ============================================================================
package ssegment_mux_display_pkg;

    // Segment bit positions within a 7-bit segment vector
    localparam int c_seg_a     = 0;
    localparam int c_seg_b     = 1;
    localparam int c_seg_c     = 2;
    localparam int c_seg_d     = 3;
    localparam int c_seg_e     = 4;
    localparam int c_seg_f     = 5;
    localparam int c_seg_g     = 6;
    localparam int c_seg_count = 7;

    // Active-high glyphs, entry 15 (F) first so that index n selects digit n
    localparam logic [15:0][c_seg_count-1:0] c_hex_glyph = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    function automatic logic [c_seg_count-1:0] hex_glyph(input logic [3:0] nibble);
        return c_hex_glyph[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssegment_mux_display_display.sv
`default_nettype none
// ============================================================================
//  Module      : ssegment_display
//  Description : Combinational hex nibble to active-high seven-segment decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module ssegment_display
    import ssegment_mux_display_pkg::*;
(
    input  logic [3:0]             value,
    output logic [c_seg_count-1:0] segments
);

    logic [c_seg_count-1:0] w_glyph;

    assign w_glyph = hex_glyph(value);

    // Output ordering is g..a from MSB to LSB
    assign segments = {w_glyph[c_seg_g], w_glyph[c_seg_f], w_glyph[c_seg_e],
                       w_glyph[c_seg_d], w_glyph[c_seg_c], w_glyph[c_seg_b],
                       w_glyph[c_seg_a]};

endmodule
`default_nettype wire

// File: rtl/ssegment_mux_display.sv
`default_nettype none
// ============================================================================
//  Module      : ssegment_mux_display
//  Description : Time-multiplexed seven-segment driver with shadow registers,
//                per-slot dead time, leading-zero suppression and frame pulse.
//                All outputs are registered (one cycle behind internal state).
//  Revision    : 1.0 - initial release
// ============================================================================
module ssegment_mux_display
    import ssegment_mux_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    en,
    input  logic                    lz_suppress,
    output logic [c_seg_count-1:0]  segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_done
);

    localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRESC_W-1:0]     c_presc_last = PRESC_W'(CLK_DIV - 1);
    localparam logic [PRESC_W-1:0]     c_blank      = PRESC_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]       c_idx_last   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0]  c_an_off     = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
    localparam logic [c_seg_count-1:0] c_seg_off    = {c_seg_count{SEG_ACTIVE_LOW != 0}};
    localparam logic                   c_dp_off     = (SEG_ACTIVE_LOW != 0);

    logic [PRESC_W-1:0]      r_presc;
    logic [IDX_W-1:0]        r_index;
    logic [4*NUM_DIGITS-1:0] r_shadow_value;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;

    logic [NUM_DIGITS-1:0]   w_zero_from;
    logic [NUM_DIGITS-1:0]   w_anode_hot;
    logic [3:0]              w_nibble;
    logic                    w_dp_bit;
    logic                    w_zero_sel;
    logic [c_seg_count-1:0]  w_glyph;
    logic                    w_suppress;
    logic                    w_show;
    logic [NUM_DIGITS-1:0]   w_anodes_next;
    logic [c_seg_count-1:0]  w_segments_next;
    logic                    w_dp_next;
    logic                    w_frame_next;

    // Shadow copy of the digits; only a load strobe changes what is shown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_value <= '0;
            r_shadow_dp    <= '0;
        end else if (load) begin
            r_shadow_value <= value;
            r_shadow_dp    <= dp_in;
        end
    end

    // Slot prescaler and digit index; disabling parks both at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_index <= '0;
        end else if (!en) begin
            r_presc <= '0;
            r_index <= '0;
        end else if (r_presc == c_presc_last) begin
            r_presc <= '0;
            r_index <= (r_index == c_idx_last) ? '0 : r_index + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // w_zero_from[i] is set when digits NUM_DIGITS-1 down to i are all zero
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_zero_from
        assign w_zero_from[i] = (r_shadow_value[4*NUM_DIGITS-1:4*i] == '0);
    end

    // Select the nibble, dp bit and suppression flag of the current digit
    always_comb begin
        w_nibble    = 4'h0;
        w_dp_bit    = 1'b0;
        w_zero_sel  = 1'b0;
        w_anode_hot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_index == IDX_W'(i)) begin
                w_nibble       = r_shadow_value[4*i +: 4];
                w_dp_bit       = r_shadow_dp[i];
                w_zero_sel     = w_zero_from[i];
                w_anode_hot[i] = 1'b1;
            end
        end
    end

    ssegment_display u_decode (
        .value    (w_nibble),
        .segments (w_glyph)
    );

    // Active-high image of the next output state; digit 0 is never suppressed
    always_comb begin
        w_suppress      = lz_suppress && (r_index != '0) && w_zero_sel;
        w_show          = en && (r_presc >= c_blank) && !w_suppress;
        w_anodes_next   = w_show ? w_anode_hot : '0;
        w_segments_next = w_show ? w_glyph : '0;
        w_dp_next       = w_show && w_dp_bit;
        w_frame_next    = en && (r_presc == c_presc_last) && (r_index == c_idx_last);
    end

    // Register outputs with the configured pin polarity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodes     <= c_an_off;
            segments   <= c_seg_off;
            dp         <= c_dp_off;
            frame_done <= 1'b0;
        end else begin
            anodes     <= w_anodes_next ^ c_an_off;
            segments   <= w_segments_next ^ c_seg_off;
            dp         <= w_dp_next ^ c_dp_off;
            frame_done <= w_frame_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ssegment_mux_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ssegment_mux_display
//  Description : Directed, table-driven bench for ssegment_mux_display with
//                NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, active-low pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ssegment_mux_display;

    localparam int ND = 4;
    localparam int CD = 8;
    localparam int BC = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load  = 1'b0;
    logic        en    = 1'b0;
    logic        lz    = 1'b0;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anodes;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpv;
        logic        lzs;
        int          digit;
        int          cycle;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dpo;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] seg_1a80 [4];

    ssegment_mux_display #(
        .NUM_DIGITS     (ND),
        .CLK_DIV        (CD),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .dp_in       (dp_in),
        .load        (load),
        .en          (en),
        .lz_suppress (lz),
        .segments    (segments),
        .dp          (dp),
        .anodes      (anodes),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges and stop on the following falling edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // From a falling edge: disable, load new shadow data, then re-enable
    task automatic start_display(input logic [15:0] v, input logic [3:0] d, input logic l);
        en    = 1'b0;
        load  = 1'b1;
        value = v;
        dp_in = d;
        lz    = l;
        step(1);
        load  = 1'b0;
        en    = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        seg_1a80[0] = 7'b1000000;
        seg_1a80[1] = 7'b0000000;
        seg_1a80[2] = 7'b0001000;
        seg_1a80[3] = 7'b1111001;

        //               value     dp     lz    dig cyc anodes   segments      dp
        vecs.push_back('{16'h1A80, 4'h0, 1'b0, 0, 2, 4'b1110, 7'b1000000, 1'b1});
        vecs.push_back('{16'h1A80, 4'h0, 1'b0, 1, 5, 4'b1101, 7'b0000000, 1'b1});
        vecs.push_back('{16'h1A80, 4'h0, 1'b0, 2, 3, 4'b1011, 7'b0001000, 1'b1});
        vecs.push_back('{16'h1A80, 4'h0, 1'b0, 3, 7, 4'b0111, 7'b1111001, 1'b1});
        vecs.push_back('{16'h1A80, 4'h0, 1'b0, 3, 1, 4'b1111, 7'b1111111, 1'b1});
        vecs.push_back('{16'h1A80, 4'h0, 1'b0, 1, 0, 4'b1111, 7'b1111111, 1'b1});
        vecs.push_back('{16'h0005, 4'h0, 1'b1, 0, 4, 4'b1110, 7'b0010010, 1'b1});
        vecs.push_back('{16'h0005, 4'h0, 1'b1, 2, 4, 4'b1111, 7'b1111111, 1'b1});
        vecs.push_back('{16'h0005, 4'h0, 1'b1, 3, 2, 4'b1111, 7'b1111111, 1'b1});
        vecs.push_back('{16'h0000, 4'h0, 1'b1, 0, 2, 4'b1110, 7'b1000000, 1'b1});
        vecs.push_back('{16'h0005, 4'h0, 1'b0, 3, 2, 4'b0111, 7'b1000000, 1'b1});
        vecs.push_back('{16'h0405, 4'h0, 1'b1, 1, 3, 4'b1101, 7'b1000000, 1'b1});
        vecs.push_back('{16'h0405, 4'h0, 1'b1, 3, 3, 4'b1111, 7'b1111111, 1'b1});
        vecs.push_back('{16'h1A80, 4'h4, 1'b0, 2, 4, 4'b1011, 7'b0001000, 1'b0});
        vecs.push_back('{16'h1A80, 4'h4, 1'b0, 1, 4, 4'b1101, 7'b0000000, 1'b1});
        vecs.push_back('{16'h1A80, 4'h4, 1'b0, 2, 1, 4'b1111, 7'b1111111, 1'b1});
        vecs.push_back('{16'hF3C7, 4'hF, 1'b0, 0, 6, 4'b1110, 7'b1111000, 1'b0});
        vecs.push_back('{16'hF3C7, 4'hF, 1'b0, 1, 2, 4'b1101, 7'b1000110, 1'b0});
        vecs.push_back('{16'hF3C7, 4'hF, 1'b0, 2, 7, 4'b1011, 7'b0110000, 1'b0});
        vecs.push_back('{16'hF3C7, 4'hF, 1'b0, 3, 5, 4'b0111, 7'b0001110, 1'b0});

        // Asynchronous reset takes effect without a clock edge
        #3 rst_n = 1'b0;
        #1;
        check("reset_anodes", anodes, 4'b1111);
        check("reset_segments", segments, 7'h7F);
        check("reset_dp", dp, 1'b1);
        check("reset_frame_done", frame_done, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Disabled display stays dark
        step(2);
        check("idle_anodes", anodes, 4'b1111);
        check("idle_frame_done", frame_done, 1'b0);

        // First enabled edge starts digit 0 slot 0 with zeroed shadow
        en = 1'b1;
        step(2);
        check("start_blank_anodes", anodes, 4'b1111);
        step(1);
        check("start_digit0_anodes", anodes, 4'b1110);
        check("start_digit0_segments", segments, 7'b1000000);

        // Table vectors: k-th enabled edge shows slot cycle (k-1)%CD of digit (k-1)/CD
        foreach (vecs[i]) begin
            start_display(vecs[i].val, vecs[i].dpv, vecs[i].lzs);
            step(vecs[i].digit * CD + vecs[i].cycle + 1);
            check($sformatf("vec%0d_anodes", i), anodes, vecs[i].an);
            check($sformatf("vec%0d_segments", i), segments, vecs[i].seg);
            check($sformatf("vec%0d_dp", i), dp, vecs[i].dpo);
        end

        // Full-frame scan: blanking, digit order and frame_done every 32 cycles
        start_display(16'h1A80, 4'h0, 1'b0);
        for (int k = 1; k <= 70; k++) begin
            int         pc;
            int         ix;
            logic [3:0] exp_an;
            logic [6:0] exp_seg;
            step(1);
            pc = (k - 1) % CD;
            ix = ((k - 1) / CD) % ND;
            exp_an  = (pc < BC) ? 4'b1111 : (4'b1111 ^ (4'b0001 << ix));
            exp_seg = (pc < BC) ? 7'h7F : seg_1a80[ix];
            check($sformatf("scan%0d_anodes", k), anodes, exp_an);
            check($sformatf("scan%0d_segments", k), segments, exp_seg);
            check($sformatf("scan%0d_frame_done", k), frame_done, (k % (CD * ND)) == 0);
        end

        // Live input change without load leaves the display alone
        value = 16'hFFFF;
        step(1);
        check("noload_segments", segments, 7'b1000000);
        check("noload_anodes", anodes, 4'b1110);

        // Load mid-slot: new glyph one cycle after capture, same anode
        start_display(16'h1A80, 4'h0, 1'b0);
        step(12);
        check("midload_before", segments, 7'b0000000);
        value = 16'h1A30;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
        check("midload_capture_edge", segments, 7'b0000000);
        check("midload_capture_anodes", anodes, 4'b1101);
        step(1);
        check("midload_new_glyph", segments, 7'b0110000);
        check("midload_new_anodes", anodes, 4'b1101);

        // Load coincident with slot change lands on the new slot
        start_display(16'h1A80, 4'h0, 1'b0);
        step(8);
        value = 16'h1A50;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
        step(2);
        check("slotload_anodes", anodes, 4'b1101);
        check("slotload_segments", segments, 7'b0010010);

        // Disable during digit 2, then re-enable from digit 0
        start_display(16'h1A80, 4'h4, 1'b0);
        step(21);
        check("endrop_before_anodes", anodes, 4'b1011);
        check("endrop_before_dp", dp, 1'b0);
        en = 1'b0;
        step(1);
        check("endrop_anodes", anodes, 4'b1111);
        check("endrop_segments", segments, 7'h7F);
        check("endrop_dp", dp, 1'b1);
        check("endrop_frame_done", frame_done, 1'b0);
        step(3);
        check("endrop_hold_anodes", anodes, 4'b1111);
        en = 1'b1;
        step(1);
        check("reen_blank1", anodes, 4'b1111);
        step(1);
        check("reen_blank2", anodes, 4'b1111);
        step(1);
        check("reen_digit0_anodes", anodes, 4'b1110);
        check("reen_digit0_segments", segments, 7'b1000000);

        // Reset mid-frame clears outputs at once and zeroes the shadow
        start_display(16'h1A87, 4'h1, 1'b0);
        step(12);
        check("midrst_before_anodes", anodes, 4'b1101);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_anodes", anodes, 4'b1111);
        check("midrst_segments", segments, 7'h7F);
        check("midrst_dp", dp, 1'b1);
        check("midrst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        check("postrst_anodes", anodes, 4'b1110);
        check("postrst_segments", segments, 7'b1000000);
        check("postrst_dp", dp, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssegment_mux_display.md
SSEGMENT_MUX_DISPLAY -- requirements
Module: ssegment_mux_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 Parameter CLK_DIV, default 50000, clock cycles per digit slot (legal >= 4).
REQ-003 Parameter BLANK_CYCLES, default 2, dead-time cycles at start of each slot with all anodes off (legal 0..CLK_DIV-2).
REQ-004 Parameter SEG_ACTIVE_LOW, default 1, 1 = segment/dp outputs active-low.
REQ-005 Parameter AN_ACTIVE_LOW, default 1, 1 = anode outputs active-low.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 value  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 rightmost.
REQ-009 dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
REQ-010 load  in  1  single-cycle strobe; captures value and dp_in into shadow registers.
REQ-011 en  in  1  display enable, active-high.
REQ-012 lz_suppress  in  1  leading-zero suppression enable.
REQ-013 segments  out  7  bit0=a ... bit6=g, polarity per SEG_ACTIVE_LOW.
REQ-014 dp  out  1  decimal point of active digit, polarity per SEG_ACTIVE_LOW.
REQ-015 anodes  out  NUM_DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW.
REQ-016 frame_done  out  1  one-cycle pulse, active-high, at end of the last digit's slot.

Function
REQ-017 Prescaler SHALL count 0..CLK_DIV-1 while en=1 and wrap to 0; at wrap the digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-018 frame_done SHALL pulse in the cycle after the prescaler wraps with index NUM_DIGITS-1.
REQ-019 Shadow registers SHALL update only on load=1; the display SHALL render shadow contents, never live value/dp_in.
REQ-020 All outputs SHALL be registered; outputs SHALL reflect prescaler/index/shadow state of the previous cycle (latency 1).
REQ-021 While prescaler < BLANK_CYCLES, all anodes SHALL be inactive; otherwise only anodes[index] SHALL be active.
REQ-022 Segment pattern SHALL be the standard hex glyph of the shadow nibble at index (0-9, A, b, C, d, E, F).
REQ-023 With lz_suppress=1, digit i (i>0) SHALL be blank (anode inactive, segments/dp inactive) when shadow nibbles NUM_DIGITS-1..i are all zero; digit 0 SHALL never be suppressed.
REQ-024 dp SHALL be active only when anode of its digit is active and the shadow dp bit is 1.
REQ-025 en=0 SHALL force anodes/segments/dp inactive, frame_done 0, and clear prescaler and index on the next edge; re-enable SHALL restart at digit 0, prescaler 0.
REQ-026 load coincident with slot change SHALL apply new shadow data to the new slot.

Reset
REQ-027 rst_n=0 SHALL immediately set anodes, segments, dp inactive, frame_done 0, prescaler 0, index 0, shadow registers 0.
REQ-028 After rst_n release, operation SHALL start at digit 0, slot cycle 0, on the first edge with en=1.

Structure
REQ-029 Shared package SHALL hold the 16-entry hex glyph table (active-high) and segment bit-index constants.
REQ-030 Hex decoding SHALL be done by one instance of sub-module ssegment_display (4-bit value -> 7 segments, active-high); polarity inversion SHALL be applied in this block.

Verification (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, both polarities active-low)
REQ-031 rst_n=0 mid-frame -> same instant anodes=4'b1111, segments=7'h7F, dp=1, frame_done=0.
REQ-032 load value=16'h1A80, en=1 -> digit0 segments 7'b1000000, digit1 7'b0000000, digit2 7'b0001000, digit3 7'b1111001; anodes 4'b1111 first 2 cycles of each slot; frame_done every 32 cycles.
REQ-033 lz_suppress=1, load 16'h0005 -> anodes[3:1] never active, digit0 shows 7'b0010010; load 16'h0000 -> digit0 shows 7'b1000000.
REQ-034 dp_in=4'b0100 loaded -> dp=0 only during digit2 non-blank cycles.
REQ-035 Change value without load -> segments unchanged; load mid-slot -> new glyph exactly 1 cycle later, anode unchanged.
REQ-036 en 1->0 during digit2 -> outputs inactive next cycle; en 0->1 -> digit0 active after 2 blank cycles.
